foc_sample_issuer: RTL and testbench

- Front-end initiator for the FOC control core.
- Each control period, a period timer triggers one ADC conversion of the three phase currents and, in the same cycle, latches the resolver angle.
- Converts offset-binary ADC codes to signed Q-format currents and issues one valid pulse carrying angle, currents and target to the core. It then tracks the core's ready handshake until the core completes.
- Counts overruns (period tick while a control cycle is still in flight) and flags ADC timeouts.

---
 rtl/foc_sample_issuer_if.sv | 31 +++
 rtl/foc_sample_issuer.sv | 146 ++++++++++++++
 tb/tb_foc_sample_issuer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/foc_sample_issuer_if.sv
// foc_sample_issuer_if: ADC and core handshake bundle for the FOC sample issuer
//   master (issuer): drives adc_start, angle_out, curr*_out, valid;
//                    samples adc_done, adc_a/b/c, ready
//   slave (ADC+core): the mirror image
interface foc_sample_issuer_if #(
    parameter int D_WIDTH   = 19,
    parameter int ADC_WIDTH = 12
);
    logic                        adc_start;
    logic                        adc_done;
    logic        [ADC_WIDTH-1:0] adc_a;
    logic        [ADC_WIDTH-1:0] adc_b;
    logic        [ADC_WIDTH-1:0] adc_c;
    logic        [D_WIDTH-1:0]   angle_out;
    logic signed [D_WIDTH-1:0]   currA_out;
    logic signed [D_WIDTH-1:0]   currB_out;
    logic signed [D_WIDTH-1:0]   currC_out;
    logic signed [D_WIDTH-1:0]   currT_out;
    logic                        valid;
    logic                        ready;

    modport master (
        output adc_start, angle_out, currA_out, currB_out, currC_out, currT_out, valid,
        input  adc_done, adc_a, adc_b, adc_c, ready
    );

    modport slave (
        input  adc_start, angle_out, currA_out, currB_out, currC_out, currT_out, valid,
        output adc_done, adc_a, adc_b, adc_c, ready
    );
endinterface

// File: rtl/foc_sample_issuer.sv
// foc_sample_issuer: period-timed ADC trigger and sample issuer for the FOC core
//   clk, rstb (async active-low)
//   enable, period_cycles : period timer control (0 period = stopped)
//   angle_in, target_in   : latched on each conversion start
//   bus (master)          : ADC start/done/codes, core valid/ready, latched outputs
//   overrun_cnt, adc_err, sum_err : saturating/sticky status, cleared by clear_flags
//   Optional phase-sum check enabled by defining FOC_SAMPLE_SUM_CHECK_EN.
module foc_sample_issuer #(
    parameter int D_WIDTH     = 19,
    parameter int Q_BITS      = 15,
    parameter int ADC_WIDTH   = 12,
    parameter int CNT_WIDTH   = 16,
    parameter int ADC_TIMEOUT = 64,
    parameter int SUM_TOL     = 1024
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       enable,
    input  logic [CNT_WIDTH-1:0]       period_cycles,
    input  logic [D_WIDTH-1:0]         angle_in,
    input  logic signed [D_WIDTH-1:0]  target_in,
    foc_sample_issuer_if.master        bus,
    output logic [CNT_WIDTH-1:0]       overrun_cnt,
    output logic                       adc_err,
    output logic                       sum_err,
    input  logic                       clear_flags
);
    localparam int SH = Q_BITS - ADC_WIDTH + 1;
    localparam int TW = $clog2(ADC_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CONVERT, ISSUE, BUSY, WAIT_DONE} state_t;

    state_t                      state;
    logic        [CNT_WIDTH-1:0] tmr;
    logic        [TW-1:0]        tcnt;
    logic                        run;
    logic                        tick;
    logic                        sum_bad;
    logic signed [D_WIDTH-1:0]   ca;
    logic signed [D_WIDTH-1:0]   cb;
    logic signed [D_WIDTH-1:0]   cc;

    // Offset-binary to two's complement is an MSB flip; then sign-extend and scale to Q format.
    function automatic logic signed [D_WIDTH-1:0] conv(input logic [ADC_WIDTH-1:0] code);
        logic [ADC_WIDTH-1:0] c;
        c = {~code[ADC_WIDTH-1], code[ADC_WIDTH-2:0]};
        return {{(D_WIDTH-ADC_WIDTH){c[ADC_WIDTH-1]}}, c} << SH;
    endfunction

    assign ca   = conv(bus.adc_a);
    assign cb   = conv(bus.adc_b);
    assign cc   = conv(bus.adc_c);
    assign run  = enable && period_cycles != '0;
    // >= rather than == so a period shrunk below the running count still wraps at once.
    assign tick = run && tmr >= period_cycles - CNT_WIDTH'(1);

`ifdef FOC_SAMPLE_SUM_CHECK_EN
    logic signed [D_WIDTH+1:0] sum;
    logic signed [D_WIDTH+1:0] mag;

    assign sum     = {{2{ca[D_WIDTH-1]}}, ca} + {{2{cb[D_WIDTH-1]}}, cb} + {{2{cc[D_WIDTH-1]}}, cc};
    assign mag     = sum[D_WIDTH+1] ? -sum : sum;
    assign sum_bad = mag > (D_WIDTH+2)'(SUM_TOL);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            sum_err <= 1'b0;
        else if (state == CONVERT && bus.adc_done && sum_bad)
            sum_err <= 1'b1;
        else if (clear_flags)
            sum_err <= 1'b0;
    end
`else
    assign sum_bad = 1'b0;
    assign sum_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            tmr <= '0;
        else
            tmr <= (!run || tick) ? '0 : tmr + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state         <= IDLE;
            tcnt          <= '0;
            overrun_cnt   <= '0;
            adc_err       <= 1'b0;
            bus.adc_start <= 1'b0;
            bus.valid     <= 1'b0;
            bus.angle_out <= '0;
            bus.currA_out <= '0;
            bus.currB_out <= '0;
            bus.currC_out <= '0;
            bus.currT_out <= '0;
        end else begin
            bus.adc_start <= 1'b0;
            bus.valid     <= 1'b0;
            // Clear beats a same-cycle overrun; a same-cycle timeout below still sets adc_err.
            if (clear_flags) begin
                overrun_cnt <= '0;
                adc_err     <= 1'b0;
            end else if (tick && state != IDLE && !(&overrun_cnt)) begin
                overrun_cnt <= overrun_cnt + CNT_WIDTH'(1);
            end
            case (state)
                IDLE: if (tick) begin
                    bus.adc_start <= 1'b1;
                    bus.angle_out <= angle_in;
                    bus.currT_out <= target_in;
                    tcnt          <= '0;
                    state         <= CONVERT;
                end
                CONVERT: begin
                    tcnt <= tcnt + TW'(1);
                    if (bus.adc_done) begin
                        bus.currA_out <= ca;
                        bus.currB_out <= cb;
                        bus.currC_out <= cc;
                        // Skip ISSUE when the core is already ready to hit one-clock issue latency.
                        if (sum_bad) begin
                            state <= IDLE;
                        end else if (bus.ready) begin
                            bus.valid <= 1'b1;
                            state     <= BUSY;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (tcnt == TW'(ADC_TIMEOUT - 1)) begin
                        adc_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                ISSUE: if (bus.ready) begin
                    bus.valid <= 1'b1;
                    state     <= BUSY;
                end
                BUSY: if (!bus.ready) state <= WAIT_DONE;
                WAIT_DONE: if (bus.ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_foc_sample_issuer.sv
// tb_foc_sample_issuer: directed bench for foc_sample_issuer with ADC and core models
module tb_foc_sample_issuer;
    localparam int DW = 19;
    localparam int AW = 12;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 enable;
    logic                 clear_flags;
    logic [CW-1:0]        period_cycles;
    logic [DW-1:0]        angle_in;
    logic signed [DW-1:0] target_in;
    logic [CW-1:0]        overrun_cnt;
    logic                 adc_err;
    logic                 sum_err;

    foc_sample_issuer_if #(.D_WIDTH(DW), .ADC_WIDTH(AW)) bus ();

    foc_sample_issuer dut (
        .clk(clk), .rstb(rstb), .enable(enable), .period_cycles(period_cycles),
        .angle_in(angle_in), .target_in(target_in), .bus(bus),
        .overrun_cnt(overrun_cnt), .adc_err(adc_err), .sum_err(sum_err),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int core_busy = 20;
    int busy_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: drops ready for core_busy cycles after each valid pulse.
    initial begin
        bus.ready = 1'b1;
        forever begin
            @(negedge clk);
            if (busy_left > 0) begin
                busy_left--;
                bus.ready = (busy_left == 0);
            end else if (bus.valid) begin
                busy_left = core_busy;
                bus.ready = 1'b0;
            end
        end
    end

    typedef struct {
        logic [DW-1:0]        ang;
        logic signed [DW-1:0] tgt;
        logic [AW-1:0]        a;
        logic [AW-1:0]        b;
        logic [AW-1:0]        c;
        longint               ea;
        longint               eb;
        longint               ec;
    } vec_t;

    vec_t vt [4];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic wait_start(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.adc_start && n < bound);
        if (!bus.adc_start) expire("adc_start");
    endtask

    // Called at the negedge where adc_start is seen; raises adc_done 10 clocks later.
    task automatic convert(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                           output logic v);
        @(negedge clk);
        check("start_pulse_width", longint'(bus.adc_start), 0);
        repeat (9) @(negedge clk);
        bus.adc_a    = a;
        bus.adc_b    = b;
        bus.adc_c    = c;
        bus.adc_done = 1'b1;
        @(negedge clk);
        bus.adc_done = 1'b0;
        v = bus.valid;
    endtask

    initial begin
        int   n;
        int   last;
        int   extra;
        logic v;
        vt[0] = '{19'h12345, -19'sd5000, 12'd2048, 12'd4095, 12'd0,    0,      32752,  -32768};
        vt[1] = '{19'h7abcd, 19'sd1234,  12'd2049, 12'd2047, 12'd3000, 16,     -16,    15232};
        vt[2] = '{19'h00001, -19'sd1,    12'd1024, 12'd3072, 12'd100,  -16384, 16384,  -31168};
        vt[3] = '{19'h40000, 19'sd0,     12'd2048, 12'd2048, 12'd2048, 0,      0,      0};
        rstb          = 1'b0;
        enable        = 1'b0;
        clear_flags   = 1'b0;
        period_cycles = 16'd100;
        angle_in      = '0;
        target_in     = '0;
        bus.adc_done  = 1'b0;
        bus.adc_a     = 12'd2048;
        bus.adc_b     = 12'd2048;
        bus.adc_c     = 12'd2048;
        last          = 0;
        repeat (3) @(negedge clk);
        check("rst_adc_start", longint'(bus.adc_start), 0);
        check("rst_valid", longint'(bus.valid), 0);
        check("rst_angle", longint'(bus.angle_out), 0);
        check("rst_currA", longint'(bus.currA_out), 0);
        check("rst_currT", longint'(bus.currT_out), 0);
        check("rst_overrun", longint'(overrun_cnt), 0);
        check("rst_adc_err", longint'(adc_err), 0);
        check("rst_sum_err", longint'(sum_err), 0);

        angle_in  = vt[0].ang;
        target_in = vt[0].tgt;
        rstb      = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(150, n);
            if (i > 0) check("period", longint'(cyc - last), 100);
            last = cyc;
            convert(vt[i].a, vt[i].b, vt[i].c, v);
            check("issue_latency", longint'(v), 1);
            check("currA", longint'(bus.currA_out), vt[i].ea);
            check("currB", longint'(bus.currB_out), vt[i].eb);
            check("currC", longint'(bus.currC_out), vt[i].ec);
            check("angle", longint'(bus.angle_out), longint'(vt[i].ang));
            check("currT", longint'(bus.currT_out), longint'(vt[i].tgt));
            if (i < 3) begin
                angle_in  = vt[i+1].ang;
                target_in = vt[i+1].tgt;
            end
        end
        check("no_overrun", longint'(overrun_cnt), 0);

        core_busy = 150;
        wait_start(150, n);
        last = cyc;
        convert(vt[1].a, vt[1].b, vt[1].c, v);
        check("ov_valid", longint'(v), 1);
        extra = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.valid) extra++;
        end while (!bus.adc_start && n < 400);
        if (!bus.adc_start) expire("ov_start");
        check("ov_interval", longint'(cyc - last), 200);
        check("ov_extra_valid", longint'(extra), 0);
        check("ov_cnt_1", longint'(overrun_cnt), 1);
        convert(vt[2].a, vt[2].b, vt[2].c, v);
        check("ov_valid2", longint'(v), 1);
        repeat (88) @(negedge clk);
        check("ov_cnt_before_clear", longint'(overrun_cnt), 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("ov_clear_wins", longint'(overrun_cnt), 0);
        core_busy = 20;

        wait_start(250, n);
        last = cyc;
        extra = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.valid) extra++;
        end while (!adc_err && n < 100);
        check("to_latency", longint'(n), 64);
        check("to_no_valid", longint'(extra), 0);
        wait_start(150, n);
        check("to_restart", longint'(cyc - last), 100);
        convert(vt[1].a, vt[1].b, vt[1].c, v);
        check("to_next_valid", longint'(v), 1);
        check("to_next_currB", longint'(bus.currB_out), vt[1].eb);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("to_cleared", longint'(adc_err), 0);
        wait_start(150, n);
        repeat (63) @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("to_set_beats_clear", longint'(adc_err), 1);

        angle_in  = vt[2].ang;
        target_in = vt[2].tgt;
        wait_start(150, n);
        convert(vt[2].a, vt[2].b, vt[2].c, v);
        check("rst_mid_valid", longint'(v), 1);
        rstb = 1'b0;
        #1;
        check("rst_mid_valid_drop", longint'(bus.valid), 0);
        check("rst_mid_angle", longint'(bus.angle_out), 0);
        check("rst_mid_currB", longint'(bus.currB_out), 0);
        check("rst_mid_currT", longint'(bus.currT_out), 0);
        check("rst_mid_adc_err", longint'(adc_err), 0);
        @(negedge clk);
        rstb = 1'b1;
        wait_start(150, n);
        check("rst_resume_delay", longint'(n), 100);
        convert(vt[3].a, vt[3].b, vt[3].c, v);
        check("rst_resume_valid", longint'(v), 1);

        wait_start(150, n);
        convert(12'd4095, 12'd4095, 12'd2048, v);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.valid) extra++;
        end
`ifdef FOC_SAMPLE_SUM_CHECK_EN
        check("sum_valid", longint'(v), 0);
        check("sum_late_valid", longint'(extra), 0);
        check("sum_err", longint'(sum_err), 1);
`else
        check("sum_valid", longint'(v), 1);
        check("sum_late_valid", longint'(extra), 0);
        check("sum_err", longint'(sum_err), 0);
`endif

        wait_start(150, n);
        enable = 1'b0;
        convert(vt[0].a, vt[0].b, vt[0].c, v);
        check("en_off_inflight_valid", longint'(v), 1);
        extra = 0;
        repeat (250) begin
            @(negedge clk);
            if (bus.adc_start) extra++;
        end
        check("en_off_no_start", longint'(extra), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
